// File: rtl/iomem_gpio_pkg.sv
// Shared register-map definitions for the iomem GPIO peripheral.
package gpio_pkg;

  typedef enum logic [2:0] {
    GPIO_OFF_OUT    = 3'd0,
    GPIO_OFF_OE     = 3'd1,
    GPIO_OFF_IN     = 3'd2,
    GPIO_OFF_RISE   = 3'd3,
    GPIO_OFF_FALL   = 3'd4,
    GPIO_OFF_STATUS = 3'd5,
    GPIO_OFF_RSVD6  = 3'd6,
    GPIO_OFF_RSVD7  = 3'd7
  } gpio_off_e;

  // Offsets at or above this value are reserved through the top of the map.
  localparam logic [2:0] GPIO_RSVD_FIRST = 3'd6;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/iomem_gpio_if.sv
// PicoSoC iomem bus bundle; the SoC is master, peripherals are slaves.
interface iomem_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/iomem_gpio_sync_edge.sv
// Pin synchroniser chain plus one-cycle-delayed copy for enabled edge detection.
module gpio_sync_edge #(
  parameter int NUM_PINS    = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_PINS-1:0] pin_in,
  input  logic [NUM_PINS-1:0] rise_en,
  input  logic [NUM_PINS-1:0] fall_en,
  output logic [NUM_PINS-1:0] sync_q,
  output logic [NUM_PINS-1:0] rise,
  output logic [NUM_PINS-1:0] fall
);

  // chain[0] samples the raw pins; chain[SYNC_STAGES-1] is the safe copy.
  logic [SYNC_STAGES-1:0][NUM_PINS-1:0] chain;
  logic [NUM_PINS-1:0]                  sync_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chain  <= '0;
      sync_d <= '0;
    end else begin
      chain  <= {chain[SYNC_STAGES-2:0], pin_in};
      sync_d <= chain[SYNC_STAGES-1];
    end
  end

  assign sync_q = chain[SYNC_STAGES-1];
  assign rise   =  sync_q & ~sync_d & rise_en;
  assign fall   = ~sync_q &  sync_d & fall_en;

endmodule

// File: rtl/iomem_gpio.sv
// GPIO peripheral on the PicoSoC iomem bus: output/OE registers, synchronised
// input readback and W1C edge interrupts driving a single level irq.
module iomem_gpio
  import gpio_pkg::*;
#(
  parameter int          NUM_PINS    = 12,
  parameter logic [7:0]  BASE_ADDR   = 8'h03,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                resetn,
  iomem_if.slave              bus,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oe,
  output logic                irq
);

  logic [NUM_PINS-1:0] out_q, oe_q, rise_en_q, fall_en_q, status_q;
  logic [NUM_PINS-1:0] status_next, clr;
  logic [NUM_PINS-1:0] sync_q, rise, fall;
  logic [NUM_PINS-1:0] wmask, wval;
  logic [31:0]         rd_val;
  logic                sel, wr, is_rsvd;
  gpio_off_e           off;
  logic                unused_bits;

  gpio_sync_edge #(
    .NUM_PINS    (NUM_PINS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .resetn  (resetn),
    .pin_in  (gpio_in),
    .rise_en (rise_en_q),
    .fall_en (fall_en_q),
    .sync_q  (sync_q),
    .rise    (rise),
    .fall    (fall)
  );

  // Gating on !ready splits a held request into exactly one acknowledged beat.
  assign sel     = bus.iomem_valid && !bus.iomem_ready &&
                   (bus.iomem_addr[31:24] == BASE_ADDR);
  assign off     = gpio_off_e'(bus.iomem_addr[4:2]);
  assign is_rsvd = (bus.iomem_addr[4:2] >= GPIO_RSVD_FIRST);
  assign wr      = sel && (|bus.iomem_wstrb) && !is_rsvd;
  assign wmask   = NUM_PINS'(strb_mask(bus.iomem_wstrb));
  assign wval    = bus.iomem_wdata[NUM_PINS-1:0];

  assign unused_bits = ^{bus.iomem_addr, bus.iomem_wdata};

  always_comb begin
    rd_val = '0;
    if (!is_rsvd) begin
      case (off)
        GPIO_OFF_OUT:    rd_val = 32'(out_q);
        GPIO_OFF_OE:     rd_val = 32'(oe_q);
        GPIO_OFF_IN:     rd_val = 32'(sync_q);
        GPIO_OFF_RISE:   rd_val = 32'(rise_en_q);
        GPIO_OFF_FALL:   rd_val = 32'(fall_en_q);
        GPIO_OFF_STATUS: rd_val = 32'(status_q);
        default:         rd_val = '0;
      endcase
    end
  end

  // New edges are OR-ed in after the clear so a coincident set wins.
  always_comb begin
    clr = '0;
    if (wr && off == GPIO_OFF_STATUS)
      clr = wval & wmask;
    status_next = (status_q & ~clr) | rise | fall;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.iomem_ready <= 1'b0;
      bus.iomem_rdata <= '0;
      out_q           <= '0;
      oe_q            <= '0;
      rise_en_q       <= '0;
      fall_en_q       <= '0;
      status_q        <= '0;
      irq             <= 1'b0;
    end else begin
      bus.iomem_ready <= sel;
      if (sel)
        bus.iomem_rdata <= rd_val;
      if (wr) begin
        case (off)
          GPIO_OFF_OUT:  out_q     <= (out_q     & ~wmask) | (wval & wmask);
          GPIO_OFF_OE:   oe_q      <= (oe_q      & ~wmask) | (wval & wmask);
          GPIO_OFF_RISE: rise_en_q <= (rise_en_q & ~wmask) | (wval & wmask);
          GPIO_OFF_FALL: fall_en_q <= (fall_en_q & ~wmask) | (wval & wmask);
          default: ;
        endcase
      end
      status_q <= status_next;
      irq      <= |status_next;
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = oe_q;

endmodule

// File: tb/tb_iomem_gpio.sv
// Directed self-checking bench for iomem_gpio (NUM_PINS=12, SYNC_STAGES=2).
module tb_iomem_gpio;

  logic        clk = 1'b0;
  logic        resetn;
  logic [11:0] gpio_in;
  logic [11:0] gpio_out;
  logic [11:0] gpio_oe;
  logic        irq;

  int passed = 0;
  int total  = 0;

  logic [31:0] rd;
  int          lat;
  logic        ra;

  iomem_if bus ();

  iomem_gpio #(
    .NUM_PINS    (12),
    .BASE_ADDR   (8'h03),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Called just after a negedge; returns just after a later negedge.
  task automatic bus_access(input logic [31:0] addr, input logic [3:0] strb,
                            input logic [31:0] data, output logic [31:0] rdv,
                            output int latency, output logic ready_after);
    latency     = -1;
    rdv         = '0;
    bus.iomem_addr  = addr;
    bus.iomem_wstrb = strb;
    bus.iomem_wdata = data;
    bus.iomem_valid = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (bus.iomem_ready) begin
        latency = c;
        rdv     = bus.iomem_rdata;
        break;
      end
    end
    @(negedge clk);
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = '0;
    @(posedge clk); #1;
    ready_after = bus.iomem_ready;
    @(negedge clk);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.iomem_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.iomem_ready); else passed++;
    total++; if (bus.iomem_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", bus.iomem_rdata); else passed++;
    total++; if (gpio_out !== 12'h000) $display("FAIL reset_out: got %h want 000", gpio_out); else passed++;
    total++; if (gpio_oe !== 12'h000) $display("FAIL reset_oe: got %h want 000", gpio_oe); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else passed++;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_gpio_write;
    bus_access(32'h0300_0000, 4'b0001, 32'hFFFF_FABC, rd, lat, ra);
    total++; if (lat !== 1) $display("FAIL wr_out_latency: got %0d want 1", lat); else passed++;
    total++; if (rd !== 32'h0) $display("FAIL wr_out_prewrite: got %h want 00000000", rd); else passed++;
    total++; if (gpio_out !== 12'h0BC) $display("FAIL wr_out_pins: got %h want 0bc", gpio_out); else passed++;
    bus_access(32'h0300_0000, 4'b0000, 32'h0, rd, lat, ra);
    total++; if (rd !== 32'h0000_00BC) $display("FAIL rd_out: got %h want 000000bc", rd); else passed++;
    total++; if (lat !== 1) $display("FAIL rd_out_latency: got %0d want 1", lat); else passed++;
    total++; if (ra !== 1'b0) $display("FAIL rd_out_ready_width: got %b want 0", ra); else passed++;
    // Aliased address for OE, then a byte-1-only write of zero.
    bus_access(32'h03FF_FFE4, 4'b1111, 32'h0000_0F0F, rd, lat, ra);
    total++; if (gpio_oe !== 12'hF0F) $display("FAIL wr_oe_alias: got %h want f0f", gpio_oe); else passed++;
    bus_access(32'h0300_0004, 4'b0010, 32'h0, rd, lat, ra);
    total++; if (rd !== 32'h0000_0F0F) $display("FAIL wr_oe_prewrite: got %h want 00000f0f", rd); else passed++;
    total++; if (gpio_oe !== 12'h00F) $display("FAIL wr_oe_byte1: got %h want 00f", gpio_oe); else passed++;
  endtask

  task automatic test_decode;
    int acks;
    acks = 0;
    bus.iomem_addr  = 32'h0400_0000;
    bus.iomem_wstrb = 4'b0000;
    bus.iomem_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.iomem_ready) acks++;
    end
    @(negedge clk);
    bus.iomem_valid = 1'b0;
    @(negedge clk);
    total++; if (acks !== 0) $display("FAIL decode_miss: got %0d acks want 0", acks); else passed++;
    bus_access(32'h0300_001C, 4'b1111, 32'hFFFF_FFFF, rd, lat, ra);
    total++; if (lat !== 1) $display("FAIL rsvd_write_ack: got %0d want 1", lat); else passed++;
    bus_access(32'h0300_0018, 4'b0000, 32'h0, rd, lat, ra);
    total++; if (lat !== 1) $display("FAIL rsvd_read_ack: got %0d want 1", lat); else passed++;
    total++; if (rd !== 32'h0) $display("FAIL rsvd_read_data: got %h want 0", rd); else passed++;
    total++; if (gpio_out !== 12'h0BC) $display("FAIL rsvd_no_side_effect: got %h want 0bc", gpio_out); else passed++;
  endtask

  task automatic test_input_sync;
    gpio_in = 12'h000;
    repeat (4) @(negedge clk);
    gpio_in[3] = 1'b1;
    bus_access(32'h0300_0008, 4'b0000, 32'h0, rd, lat, ra);
    total++; if (rd !== 32'h0) $display("FAIL in_sync_1cyc: got %h want 0", rd); else passed++;
    gpio_in[3] = 1'b0;
    repeat (4) @(negedge clk);
    gpio_in[3] = 1'b1;
    @(negedge clk);
    bus_access(32'h0300_0008, 4'b0000, 32'h0, rd, lat, ra);
    total++; if (rd !== 32'h0) $display("FAIL in_sync_2cyc: got %h want 0", rd); else passed++;
    gpio_in[3] = 1'b0;
    repeat (4) @(negedge clk);
    gpio_in[3] = 1'b1;
    repeat (2) @(negedge clk);
    bus_access(32'h0300_0008, 4'b0000, 32'h0, rd, lat, ra);
    total++; if (rd !== 32'h0000_0008) $display("FAIL in_sync_3cyc: got %h want 00000008", rd); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL in_no_irq_disabled: got %b want 0", irq); else passed++;
    gpio_in[3] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_rise_irq;
    bus_access(32'h0300_000C, 4'b0011, 32'h0000_0008, rd, lat, ra);
    gpio_in[3] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    total++; if (irq !== 1'b0) $display("FAIL rise_irq_early: got %b want 0", irq); else passed++;
    @(posedge clk); #1;
    total++; if (irq !== 1'b1) $display("FAIL rise_irq_on_time: got %b want 1", irq); else passed++;
    @(negedge clk);
    bus_access(32'h0312_3414, 4'b0000, 32'h0, rd, lat, ra);
    total++; if (rd !== 32'h0000_0008) $display("FAIL rise_status: got %h want 00000008", rd); else passed++;
    bus_access(32'h0300_000C, 4'b0011, 32'h0, rd, lat, ra);
    bus_access(32'h0300_0014, 4'b0000, 32'h0, rd, lat, ra);
    total++; if (rd !== 32'h0000_0008) $display("FAIL status_kept_after_disable: got %h want 00000008", rd); else passed++;
    // W1C with wrong strobe byte must not clear.
    bus_access(32'h0300_0014, 4'b0010, 32'h0000_0008, rd, lat, ra);
    total++; if (irq !== 1'b1) $display("FAIL w1c_wrong_strobe: got %b want 1", irq); else passed++;
    bus_access(32'h0300_0014, 4'b0001, 32'h0000_0008, rd, lat, ra);
    total++; if (rd !== 32'h0000_0008) $display("FAIL w1c_prewrite: got %h want 00000008", rd); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL w1c_irq_clear: got %b want 0", irq); else passed++;
  endtask

  task automatic test_fall_set_over_clear;
    bus_access(32'h0300_0010, 4'b0001, 32'h0000_0001, rd, lat, ra);
    gpio_in[0] = 1'b1;
    repeat (5) @(negedge clk);
    gpio_in[0] = 1'b0;
    repeat (2) @(negedge clk);
    bus_access(32'h0300_0014, 4'b0001, 32'h0000_0001, rd, lat, ra);
    total++; if (rd !== 32'h0) $display("FAIL collide_prewrite: got %h want 0", rd); else passed++;
    total++; if (irq !== 1'b1) $display("FAIL collide_irq: got %b want 1", irq); else passed++;
    bus_access(32'h0300_0014, 4'b0000, 32'h0, rd, lat, ra);
    total++; if (rd !== 32'h0000_0001) $display("FAIL collide_set_wins: got %h want 00000001", rd); else passed++;
    bus_access(32'h0300_0014, 4'b0001, 32'h0000_0001, rd, lat, ra);
    total++; if (irq !== 1'b0) $display("FAIL fall_w1c: got %b want 0", irq); else passed++;
  endtask

  task automatic test_reset_mid_access;
    int acks;
    acks = 0;
    bus_access(32'h0300_000C, 4'b0001, 32'h0000_0001, rd, lat, ra);
    gpio_in[0] = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (irq !== 1'b1) $display("FAIL mid_pre_irq: got %b want 1", irq); else passed++;
    bus.iomem_addr  = 32'h0300_0000;
    bus.iomem_wstrb = 4'b0000;
    bus.iomem_valid = 1'b1;
    #2 resetn = 1'b0;
    #1;
    total++; if (bus.iomem_ready !== 1'b0) $display("FAIL mid_ready: got %b want 0", bus.iomem_ready); else passed++;
    total++; if (gpio_oe !== 12'h000) $display("FAIL mid_oe: got %h want 000", gpio_oe); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL mid_irq: got %b want 0", irq); else passed++;
    total++; if (gpio_out !== 12'h000) $display("FAIL mid_out: got %h want 000", gpio_out); else passed++;
    @(negedge clk);
    bus.iomem_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (bus.iomem_ready) acks++;
    end
    @(negedge clk);
    total++; if (acks !== 0) $display("FAIL mid_no_stale_ack: got %0d want 0", acks); else passed++;
    bus_access(32'h0300_0000, 4'b0000, 32'h0, rd, lat, ra);
    total++; if (lat !== 1) $display("FAIL mid_reissue_latency: got %0d want 1", lat); else passed++;
    total++; if (rd !== 32'h0) $display("FAIL mid_reissue_data: got %h want 0", rd); else passed++;
    bus_access(32'h0300_0014, 4'b0000, 32'h0, rd, lat, ra);
    total++; if (rd !== 32'h0) $display("FAIL mid_no_edge_after_reset: got %h want 0", rd); else passed++;
  endtask

  initial begin
    resetn          = 1'b0;
    gpio_in         = '0;
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = '0;
    bus.iomem_addr  = '0;
    bus.iomem_wdata = '0;
    test_reset();
    test_gpio_write();
    test_decode();
    test_input_sync();
    test_rise_irq();
    test_fall_set_over_clear();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/iomem_gpio.md
# iomem_gpio

Parametrised GPIO peripheral for the PicoSoC iomem bus, replacing the fixed 32-bit output-only register in the board top. It provides per-pin output, output-enable, synchronised input readback, and rising/falling edge interrupts with write-1-to-clear status. It sits beside the SoC in the board top level, decodes one 16 MB region of iomem space, and drives one `irq_N` line into the SoC.

## Interface

Parameters:

- `NUM_PINS`, 12, number of GPIO pins (1..32).
- `BASE_ADDR`, 8'h03, value matched against `iomem_addr[31:24]`.
- `SYNC_STAGES`, 2, input synchroniser depth (≥2).

Ports:

- `clk` in 1: single clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `iomem_valid` in 1: request valid, held until `iomem_ready`.
- `iomem_ready` out 1: one-cycle acknowledge.
- `iomem_wstrb` in 4: byte write strobes; 0 = read.
- `iomem_addr` in 32: byte address.
- `iomem_wdata` in 32: write data.
- `iomem_rdata` out 32: read data, valid while `iomem_ready`=1.
- `gpio_in` in NUM_PINS: raw asynchronous pin inputs.
- `gpio_out` out NUM_PINS: output data.
- `gpio_oe` out NUM_PINS: per-pin output enable, 1 = drive.
- `irq` out 1: level interrupt, `|IRQ_STATUS`.

## Operation

- Select: `iomem_valid && !iomem_ready && iomem_addr[31:24]==BASE_ADDR`. Non-matching addresses are never acknowledged.
- Register offset: `iomem_addr[4:2]`. Bits [23:5] and [1:0] are ignored, so the register map aliases across the region.
  - 0 `OUT` RW
  - 1 `OE` RW
  - 2 `IN` RO (synchronised pins)
  - 3 `RISE_EN` RW
  - 4 `FALL_EN` RW
  - 5 `IRQ_STATUS` W1C
  - 6, 7 reserved: read 0, writes ignored, still acknowledged.
- Writes honour each `iomem_wstrb` byte independently. Register bits ≥ NUM_PINS are not stored and read 0.
- Every selected access returns the pre-write value of the addressed register in `iomem_rdata`, for reads and writes alike.
- Edge detect runs on the synchronised input against its one-cycle-delayed copy:
  - `rise = s & ~s_d & RISE_EN`
  - `fall = ~s & s_d & FALL_EN`
- `IRQ_STATUS[i]` is set by `rise[i] | fall[i]` and cleared by writing 1 to it (with the byte strobe set). If set and clear hit the same bit in the same cycle, set wins.
- Writing 0 to an enable bit does not clear an already-set status bit.
- `irq = |IRQ_STATUS`, registered.

## Timing

- Reset values: `iomem_ready`=0, `iomem_rdata`=0, `gpio_out`=0, `gpio_oe`=0, `irq`=0. All registers, synchroniser stages and `s_d` reset to 0.
- Access latency is 1 cycle: `iomem_ready` rises in the cycle after `iomem_valid` is first seen with a matching address, and stays high for exactly 1 cycle. Back-to-back accesses are therefore separated by at least one idle-ready cycle.
- `gpio_out` and `gpio_oe` update in the same edge that raises `iomem_ready`.
- Pin to `IN` readable: SYNC_STAGES cycles.
- Pin edge to `IRQ_STATUS` set: SYNC_STAGES+1 cycles. `irq` follows in the same edge.
- Pulses shorter than one `clk` period may be missed; this is acceptable.
- A reset asserted mid-transaction forces `iomem_ready`=0 immediately. The transaction is lost, and the master must re-issue it after reset.
- A `resetn` rise coinciding with a high pin generates no edge, because `s_d` and `s` start from 0 and the first sampled 1 is a rising edge only if `RISE_EN` is already set, which it is not after reset.

## Structure

- Package `gpio_pkg` holds the offset constants (`GPIO_OFF_OUT`..`GPIO_OFF_STATUS`) and the reserved-offset range.
- Sub-module `gpio_sync_edge` (parameters NUM_PINS, SYNC_STAGES) contains the synchroniser chain, the delayed copy, and the `rise`/`fall` vectors.
- The top module holds the bus decode, the registers and the `irq`.

## Test plan

- **Reset and GPIO write:** NUM_PINS=12, reset.
  - Write `OUT`=32'hFFFF_FABC with wstrb=4'b0001 → `gpio_out`=12'h0BC.
  - Read `OUT` → 32'h0000_00BC, with `iomem_ready` high for exactly 1 cycle, 1 cycle after valid.
- **Address decode:** access at 32'h0400_0000 → no `iomem_ready` for 10 cycles. Read offset 6 → rdata 0, acknowledged.
- **Input sync:** toggle `gpio_in[3]` 0→1 → `IN` bit 3 reads 1 no earlier than SYNC_STAGES cycles later.
- **Rising-edge IRQ:** `RISE_EN`=12'h008, drive pin 3 0→1 → `IRQ_STATUS`=12'h008 and `irq`=1 at SYNC_STAGES+1 cycles. Then W1C 32'h8 → `irq`=0 next cycle.
- **Falling-edge IRQ and set-over-clear:** with `FALL_EN` bit 0 set, time a pin-0 falling edge to land in the same cycle as the W1C of bit 0 → bit 0 remains 1.
- **Reset mid-access:** assert `resetn`=0 while `iomem_valid`=1, before ready → `iomem_ready`=0, `gpio_oe`=0, `irq`=0 immediately, and no ack after release until the request is re-issued.
